ct_vfdsu_iter_sched: RTL and testbench
======================================

CT_VFDSU_ITER_SCHED -- requirements
Module: ct_vfdsu_iter_sched

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 forever_cpuclk  in  1  sole clock.
REQ-003 cpurst  in  1  synchronous reset, active-high.
REQ-004 idu_vfpu_rf_pipex_sel  in  1  issue request for a scalar div/sqrt.
REQ-005 idu_vfpu_rf_pipex_func  in  20  op decode: [0] div, [1] sqrt, [16] double, [15] single, [14] half, [13] bfloat.
REQ-006 ex1_special  in  1  operands are NaN/Inf/zero/denorm-bypass, so no iteration is needed.
REQ-007 rtu_yy_xx_flush  in  1  pipeline flush.
REQ-008 vfpu_wb_grant  in  1  writeback port granted this cycle.
REQ-009 vfdsu_idu_busy  out  1  unit is occupied; the IDU must not issue.
REQ-010 ex1_pipedown, ex2_pipedown, ex3_pipedown  out  1 each  stage-advance strobes to the datapath.
REQ-011 ex1_gateclk_en, ex2_gateclk_en, ex3_gateclk_en  out  1 each  ICG local enables for the stage clocks.
REQ-012 srt_iter_vld  out  1  SRT iteration step enable.
REQ-013 srt_iter_cnt  out  5  remaining iterations.
REQ-014 srt_first_iter  out  1  first iteration of the operation.
REQ-015 vfdsu_wb_req  out  1  result is ready for writeback.

Function
REQ-016 The FSM SHALL have the states IDLE, EX1, ITER, RND, WB, encoded in the shared package.
REQ-017 IDLE -> EX1 SHALL occur when sel=1 and func[0] or func[1] is set; all other requests SHALL be ignored.
REQ-018 In EX1, srt_iter_cnt SHALL load the precision count: double 28, single 13, half 7, bfloat 5. If no precision bit is set, the double count SHALL be used.
REQ-019 EX1 SHALL last exactly 1 cycle and assert ex1_pipedown=1. It SHALL exit to RND if ex1_special=1, otherwise to ITER.
REQ-020 In ITER, srt_iter_vld SHALL be 1 and srt_iter_cnt SHALL decrement every cycle. srt_first_iter SHALL be 1 only on the first ITER cycle.
REQ-021 ITER SHALL exit to RND in the cycle that srt_iter_cnt=1, asserting ex2_pipedown=1 in that cycle. A special operation SHALL assert ex2_pipedown on its EX1 exit cycle instead.
REQ-022 RND SHALL last exactly 1 cycle, assert ex3_pipedown=1, and go to WB.
REQ-023 WB SHALL hold vfdsu_wb_req=1 until vfpu_wb_grant=1, then go to IDLE the next cycle. A grant outside WB SHALL be ignored.
REQ-024 vfdsu_idu_busy SHALL be 1 in every state except IDLE. An issue in the same cycle as the return to IDLE is not accepted.
REQ-025 Latency from issue to wb_req SHALL be: double 31, single 16, half 10, bfloat 8, special 3 cycles, assuming an immediate grant.
REQ-026 Each exN_gateclk_en SHALL equal exN_pipedown OR'd with its state-active term: ex1 in EX1, ex2 in ITER, ex3 in RND. This guarantees the datapath is clocked whenever it advances.
REQ-027 Flush SHALL force IDLE next cycle from any state, clear srt_iter_cnt, and suppress all pipedowns and wb_req in the flush cycle.
REQ-028 A flush coinciding with an issue SHALL take priority over the issue: the issue is discarded.
REQ-029 A flush coinciding with a grant in WB SHALL drop the result.
REQ-030 srt_iter_cnt SHALL never underflow; it SHALL hold 0 outside ITER.

Reset
REQ-031 On cpurst=1 at a clock edge: state=IDLE, srt_iter_cnt=0, and every output=0.
REQ-032 Reset mid-operation SHALL abandon the operation with no wb_req.
REQ-033 Reset SHALL dominate flush and issue.

Structure
REQ-034 The state encoding and the iteration-count constants (28/13/7/5) SHALL reside in the vfdsu package.
REQ-035 The block SHALL be a single module with no sub-modules; the iteration counter SHALL be inline.

Verification
REQ-036 Double div issue, grant held 1: ex1_pipedown at cycle 1, 28 srt_iter_vld cycles, ex3_pipedown at cycle 30, wb_req at cycle 31, IDLE at cycle 32.
REQ-037 Single sqrt with grant held 0 for 5 cycles in WB: wb_req stays 1 for 6 cycles and busy stays 1 throughout.
REQ-038 Half div with ex1_special=1: zero srt_iter_vld cycles and wb_req at cycle 3.
REQ-039 Flush at ITER cycle 10 of a double op: IDLE next cycle, cnt=0, no wb_req; a new bfloat issue afterwards completes in 8 cycles.
REQ-040 cpurst=1 during WB with grant=1: all outputs 0 on the next cycle and no writeback occurs.
REQ-041 Issue asserted while busy, or with func[1:0]=0: ignored, FSM state unchanged.

Source files
------------

// File: rtl/ct_vfdsu_iter_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_vfdsu_iter_sched_pkg
// Description : Shared types and constants for the VFDSU iteration scheduler.
//               Holds the scheduler state encoding, the per-precision SRT
//               iteration counts and the precision-to-count decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_vfdsu_iter_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EX1  = 3'd1,
    S_ITER = 3'd2,
    S_RND  = 3'd3,
    S_WB   = 3'd4
  } sched_state_t;

  // SRT iteration counts per precision
  localparam logic [4:0] c_iter_double = 5'd28;
  localparam logic [4:0] c_iter_single = 5'd13;
  localparam logic [4:0] c_iter_half   = 5'd7;
  localparam logic [4:0] c_iter_bfloat = 5'd5;

  // prec = {double, single, half, bfloat}. Wider precision wins if several
  // bits are set; an empty selection falls back to the double count.
  function automatic logic [4:0] prec_iter_cnt(input logic [3:0] prec);
    logic [4:0] cnt;
    if (prec[3])      cnt = c_iter_double;
    else if (prec[2]) cnt = c_iter_single;
    else if (prec[1]) cnt = c_iter_half;
    else if (prec[0]) cnt = c_iter_bfloat;
    else              cnt = c_iter_double;
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_vfdsu_iter_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ct_vfdsu_iter_sched_if
// Description : Control bundle between the IDU/RTU/writeback side and the
//               VFDSU iteration scheduler.
//   master : drives sel, func, ex1_special, flush, wb_grant
//   slave  : drives busy, ex1..3 pipedown / gateclk_en, srt_iter_vld,
//            srt_iter_cnt, srt_first_iter, vfdsu_wb_req
// Revision    : 1.0 - initial release
// ============================================================================
interface ct_vfdsu_iter_sched_if;
  logic        idu_vfpu_rf_pipex_sel;
  logic [19:0] idu_vfpu_rf_pipex_func;
  logic        ex1_special;
  logic        rtu_yy_xx_flush;
  logic        vfpu_wb_grant;

  logic        vfdsu_idu_busy;
  logic        ex1_pipedown;
  logic        ex2_pipedown;
  logic        ex3_pipedown;
  logic        ex1_gateclk_en;
  logic        ex2_gateclk_en;
  logic        ex3_gateclk_en;
  logic        srt_iter_vld;
  logic [4:0]  srt_iter_cnt;
  logic        srt_first_iter;
  logic        vfdsu_wb_req;

  modport master (
    output idu_vfpu_rf_pipex_sel, idu_vfpu_rf_pipex_func, ex1_special,
           rtu_yy_xx_flush, vfpu_wb_grant,
    input  vfdsu_idu_busy, ex1_pipedown, ex2_pipedown, ex3_pipedown,
           ex1_gateclk_en, ex2_gateclk_en, ex3_gateclk_en,
           srt_iter_vld, srt_iter_cnt, srt_first_iter, vfdsu_wb_req
  );

  modport slave (
    input  idu_vfpu_rf_pipex_sel, idu_vfpu_rf_pipex_func, ex1_special,
           rtu_yy_xx_flush, vfpu_wb_grant,
    output vfdsu_idu_busy, ex1_pipedown, ex2_pipedown, ex3_pipedown,
           ex1_gateclk_en, ex2_gateclk_en, ex3_gateclk_en,
           srt_iter_vld, srt_iter_cnt, srt_first_iter, vfdsu_wb_req
  );
endinterface
`default_nettype wire

// File: rtl/ct_vfdsu_iter_sched.sv
`default_nettype none
// ============================================================================
// Module      : ct_vfdsu_iter_sched
// Description : Control FSM for the scalar div/sqrt unit. Accepts an issue,
//               runs EX1, counts SRT iterations for the selected precision,
//               rounds, then holds a writeback request until granted.
// Ports       : forever_cpuclk - sole clock
//               cpurst         - synchronous active-high reset
//               sched          - control bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module ct_vfdsu_iter_sched
  import ct_vfdsu_iter_sched_pkg::*;
(
  input  wire                    forever_cpuclk,
  input  wire                    cpurst,
  ct_vfdsu_iter_sched_if.slave   sched
);

  sched_state_t r_state;
  logic [4:0]   r_cnt;
  logic [4:0]   r_prec_cnt;
  logic         r_first;

  logic w_issue;
  logic w_kill;
  logic w_st_ex1;
  logic w_st_iter;
  logic w_st_rnd;
  logic w_st_wb;
  logic w_unused_func;

  assign w_issue   = sched.idu_vfpu_rf_pipex_sel & (|sched.idu_vfpu_rf_pipex_func[1:0]);
  // Reset or flush in the current cycle squashes every advance strobe and the
  // writeback request, so a dying op can never hand off or write back.
  assign w_kill    = cpurst | sched.rtu_yy_xx_flush;
  assign w_st_ex1  = (r_state == S_EX1);
  assign w_st_iter = (r_state == S_ITER);
  assign w_st_rnd  = (r_state == S_RND);
  assign w_st_wb   = (r_state == S_WB);
  assign w_unused_func = ^{sched.idu_vfpu_rf_pipex_func[19:17],
                           sched.idu_vfpu_rf_pipex_func[12:2]};

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_prec_cnt <= 5'd0;
      r_first    <= 1'b0;
    end else if (sched.rtu_yy_xx_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_EX1;
            // func is only valid in the issue cycle, so capture the count now
            r_prec_cnt <= prec_iter_cnt(sched.idu_vfpu_rf_pipex_func[16:13]);
          end
        end
        S_EX1: begin
          if (sched.ex1_special) begin
            r_state <= S_RND;
          end else begin
            r_state <= S_ITER;
            r_cnt   <= r_prec_cnt;
            r_first <= 1'b1;
          end
        end
        S_ITER: begin
          r_first <= 1'b0;
          // <=1 rather than ==1 keeps the counter from wrapping if ever 0
          if (r_cnt <= 5'd1) begin
            r_cnt   <= 5'd0;
            r_state <= S_RND;
          end else begin
            r_cnt   <= r_cnt - 5'd1;
          end
        end
        S_RND: begin
          r_state <= S_WB;
        end
        S_WB: begin
          if (sched.vfpu_wb_grant) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 5'd0;
          r_first <= 1'b0;
        end
      endcase
    end
  end

  assign sched.vfdsu_idu_busy = (r_state != S_IDLE);
  assign sched.ex1_pipedown   = w_st_ex1 & ~w_kill;
  // A special op skips ITER, so it hands EX2 forward on its EX1 exit
  assign sched.ex2_pipedown   = ((w_st_iter & (r_cnt <= 5'd1)) |
                                 (w_st_ex1 & sched.ex1_special)) & ~w_kill;
  assign sched.ex3_pipedown   = w_st_rnd & ~w_kill;
  assign sched.ex1_gateclk_en = sched.ex1_pipedown | w_st_ex1;
  assign sched.ex2_gateclk_en = sched.ex2_pipedown | w_st_iter;
  assign sched.ex3_gateclk_en = sched.ex3_pipedown | w_st_rnd;
  assign sched.srt_iter_vld   = w_st_iter;
  assign sched.srt_iter_cnt   = r_cnt;
  assign sched.srt_first_iter = w_st_iter & r_first;
  assign sched.vfdsu_wb_req   = w_st_wb & ~w_kill;

endmodule
`default_nettype wire

// File: tb/tb_ct_vfdsu_iter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_vfdsu_iter_sched
// Description : Self-checking bench for ct_vfdsu_iter_sched. A driver issues
//               directed ops and queues the expected writeback behaviour; a
//               monitor pops and compares when the DUT raises its request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_vfdsu_iter_sched;

  logic clk;
  logic cpurst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_wb = 0;

  ct_vfdsu_iter_sched_if sif ();

  ct_vfdsu_iter_sched dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .sched          (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int issue;
    int lat;
    int iters;
    int cnt0;
    int wb_len;
  } exp_t;
  exp_t sb[$];

  localparam logic [19:0] F_DIV  = 20'h00001;
  localparam logic [19:0] F_SQRT = 20'h00002;
  localparam logic [19:0] F_DBL  = 20'h10000;
  localparam logic [19:0] F_SGL  = 20'h08000;
  localparam logic [19:0] F_HALF = 20'h04000;
  localparam logic [19:0] F_BF   = 20'h02000;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [14:0] outs();
    return {sif.vfdsu_idu_busy, sif.ex1_pipedown, sif.ex2_pipedown, sif.ex3_pipedown,
            sif.ex1_gateclk_en, sif.ex2_gateclk_en, sif.ex3_gateclk_en,
            sif.srt_iter_vld, sif.srt_iter_cnt, sif.srt_first_iter, sif.vfdsu_wb_req};
  endfunction

  // Position just after the rising edge that starts cycle c
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Position mid-cycle c, away from both edges, for sampling
  task automatic at(input int c);
    goto(c);
    #3;
  endtask

  task automatic push(input int issue, input int lat, input int iters,
                      input int cnt0, input int wb_len);
    exp_t e;
    e.issue = issue; e.lat = lat; e.iters = iters; e.cnt0 = cnt0; e.wb_len = wb_len;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    int   obs_iters = 0;
    int   wb_run = 0;
    bit   prev_wb = 0;
    bit   cur_vld = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (sif.ex1_pipedown === 1'b1) obs_iters = 0;
      if (sif.srt_iter_vld === 1'b1) obs_iters++;
      if (sif.srt_first_iter === 1'b1 && sb.size() > 0)
        chk("first_iter_cnt", int'(sif.srt_iter_cnt), sb[0].cnt0);
      if (sif.vfdsu_wb_req === 1'b1 && !prev_wb) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected_qsize", sb.size(), 1);
        end else begin
          cur = sb.pop_front();
          cur_vld = 1;
          wb_run = 0;
          chk("wb_latency", cyc - cur.issue, cur.lat);
          chk("iter_cycles", obs_iters, cur.iters);
        end
      end
      if (sif.vfdsu_wb_req === 1'b1) wb_run++;
      if (sif.vfdsu_wb_req !== 1'b1 && prev_wb && cur_vld) begin
        chk("wb_hold_len", wb_run, cur.wb_len);
        cur_vld = 0;
        n_wb++;
      end
      prev_wb = (sif.vfdsu_wb_req === 1'b1);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    int busy_cnt;
    cpurst = 1'b1;
    sif.idu_vfpu_rf_pipex_sel  = 1'b0;
    sif.idu_vfpu_rf_pipex_func = '0;
    sif.ex1_special            = 1'b0;
    sif.rtu_yy_xx_flush        = 1'b0;
    sif.vfpu_wb_grant          = 1'b0;

    // Reset state
    at(2);
    chk("reset_outs", int'(outs()), 0);
    chk("reset_cnt", int'(sif.srt_iter_cnt), 0);
    goto(3); cpurst = 1'b0;

    // Double div, grant held high
    goto(5);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_DBL;
    sif.vfpu_wb_grant = 1'b1;
    push(5, 31, 28, 28, 1);
    goto(6); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    #3;
    chk("dbl_ex1_pipedown", int'(sif.ex1_pipedown), 1);
    chk("dbl_busy", int'(sif.vfdsu_idu_busy), 1);
    chk("dbl_ex1_cnt_zero", int'(sif.srt_iter_cnt), 0);
    at(34);
    chk("dbl_ex2_pipedown", int'(sif.ex2_pipedown), 1);
    at(35);
    chk("dbl_ex3_pipedown", int'(sif.ex3_pipedown), 1);
    chk("dbl_rnd_cnt_zero", int'(sif.srt_iter_cnt), 0);
    at(37);
    chk("dbl_idle", int'(sif.vfdsu_idu_busy), 0);

    // Single sqrt, grant withheld for 5 WB cycles
    goto(40);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_SQRT | F_SGL;
    sif.vfpu_wb_grant = 1'b0;
    push(40, 16, 13, 13, 6);
    goto(41); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    busy_cnt = 0;
    for (int c = 56; c <= 61; c++) begin
      goto(c);
      if (c == 61) sif.vfpu_wb_grant = 1'b1;
      #3;
      if (sif.vfdsu_idu_busy === 1'b1 && sif.vfdsu_wb_req === 1'b1) busy_cnt++;
    end
    chk("sgl_busy_wb_cycles", busy_cnt, 6);
    at(62);
    chk("sgl_idle", int'(sif.vfdsu_idu_busy), 0);

    // Half div, special operands
    goto(70);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_HALF;
    sif.ex1_special = 1'b1;
    push(70, 3, 0, 0, 1);
    goto(71); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    #3;
    chk("spc_ex2_pipedown", int'(sif.ex2_pipedown), 1);
    chk("spc_ex2_gateclk", int'(sif.ex2_gateclk_en), 1);
    goto(72); sif.ex1_special = 1'b0;

    // Double div flushed at its 10th ITER cycle
    goto(80);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_DBL;
    goto(81); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    goto(91); sif.rtu_yy_xx_flush = 1'b1;
    #3;
    chk("flush_iter_cnt", int'(sif.srt_iter_cnt), 19);
    goto(92); sif.rtu_yy_xx_flush = 1'b0;
    #3;
    chk("flush_idle", int'(sif.vfdsu_idu_busy), 0);
    chk("flush_cnt_zero", int'(sif.srt_iter_cnt), 0);

    // Bfloat div after the flush
    goto(95);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_BF;
    push(95, 8, 5, 5, 1);
    goto(96); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    at(104);
    chk("bf_idle", int'(sif.vfdsu_idu_busy), 0);

    // Flush coinciding with issue
    goto(106);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_SGL;
    sif.rtu_yy_xx_flush = 1'b1;
    goto(107);
    sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    sif.rtu_yy_xx_flush = 1'b0;
    #3;
    chk("flush_issue_drop", int'(sif.vfdsu_idu_busy), 0);

    // Issue with no div/sqrt bit
    goto(110);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DBL;
    goto(111); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    #3;
    chk("nofunc_ignored", int'(sif.vfdsu_idu_busy), 0);

    // Issue while busy, and issue in the return-to-IDLE cycle
    goto(115);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV;
    push(115, 31, 28, 28, 1);
    goto(116); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    goto(120);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_SQRT | F_SGL;
    goto(121); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    #3;
    chk("busy_issue_cnt", int'(sif.srt_iter_cnt), 24);
    goto(146);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_BF;
    goto(147); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    #3;
    chk("idle_return_issue_drop", int'(sif.vfdsu_idu_busy), 0);

    // Reset during WB with grant
    goto(150);
    sif.idu_vfpu_rf_pipex_sel = 1'b1; sif.idu_vfpu_rf_pipex_func = F_DIV | F_SGL;
    sif.vfpu_wb_grant = 1'b0;
    goto(151); sif.idu_vfpu_rf_pipex_sel = 1'b0; sif.idu_vfpu_rf_pipex_func = '0;
    at(165);
    chk("rst_pre_rnd", int'(sif.ex3_pipedown), 1);
    goto(166); cpurst = 1'b1; sif.vfpu_wb_grant = 1'b1;
    #3;
    chk("rst_wb_req_squash", int'(sif.vfdsu_wb_req), 0);
    goto(167); cpurst = 1'b0;
    #3;
    chk("rst_outs_after", int'(outs()), 0);

    at(175);
    chk("sb_empty", sb.size(), 0);
    chk("wb_count", n_wb, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
